// File: rtl/rs_alu_issue_queue.sv
// ALU reservation station: buffers dispatched ops, wakes operands from two writeback buses,
// and issues the lowest-index ready entry each cycle. Handles mispredict kill and spec-bit clear.
module rs_alu_issue_queue #(
    parameter int ENTRY_NUM   = 8,
    parameter int DATA_LEN    = 32,
    parameter int ADDR_LEN    = 32,
    parameter int RRF_SEL     = 6,
    parameter int SPECTAG_LEN = 5,
    parameter int ALU_OP_W    = 4,
    parameter int SRC_SEL_W   = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         dp_valid,
    output logic                         dp_ready,
    input  logic [DATA_LEN-1:0]          dp_src1,
    input  logic [DATA_LEN-1:0]          dp_src2,
    input  logic                         dp_rdy1,
    input  logic                         dp_rdy2,
    input  logic [ADDR_LEN-1:0]          dp_pc,
    input  logic [DATA_LEN-1:0]          dp_imm,
    input  logic [RRF_SEL-1:0]           dp_rrftag,
    input  logic                         dp_dstval,
    input  logic [SRC_SEL_W-1:0]         dp_src_a,
    input  logic [SRC_SEL_W-1:0]         dp_src_b,
    input  logic [ALU_OP_W-1:0]          dp_alu_op,
    input  logic [SPECTAG_LEN-1:0]       dp_spectag,
    input  logic                         dp_specbit,
    input  logic                         wb0_valid,
    input  logic [RRF_SEL-1:0]           wb0_tag,
    input  logic [DATA_LEN-1:0]          wb0_data,
    input  logic                         wb1_valid,
    input  logic [RRF_SEL-1:0]           wb1_tag,
    input  logic [DATA_LEN-1:0]          wb1_data,
    input  logic                         prmiss,
    input  logic                         prsuccess,
    input  logic [SPECTAG_LEN-1:0]       spectagfix,
    output logic                         iss_valid,
    output logic [DATA_LEN-1:0]          iss_src1,
    output logic [DATA_LEN-1:0]          iss_src2,
    output logic [ADDR_LEN-1:0]          iss_pc,
    output logic [DATA_LEN-1:0]          iss_imm,
    output logic [RRF_SEL-1:0]           iss_rrftag,
    output logic                         iss_dstval,
    output logic [SRC_SEL_W-1:0]         iss_src_a,
    output logic [SRC_SEL_W-1:0]         iss_src_b,
    output logic [ALU_OP_W-1:0]          iss_alu_op,
    output logic [SPECTAG_LEN-1:0]       iss_spectag,
    output logic                         iss_specbit,
    output logic [$clog2(ENTRY_NUM):0]   count
);
    localparam int IDX_W = $clog2(ENTRY_NUM);
    localparam int CNT_W = IDX_W + 1;

    logic [ENTRY_NUM-1:0]   valid, rdy1, rdy2, dstval, specbit;
    logic [DATA_LEN-1:0]    src1 [ENTRY_NUM];
    logic [DATA_LEN-1:0]    src2 [ENTRY_NUM];
    logic [DATA_LEN-1:0]    imm [ENTRY_NUM];
    logic [ADDR_LEN-1:0]    pc [ENTRY_NUM];
    logic [RRF_SEL-1:0]     rrftag [ENTRY_NUM];
    logic [SRC_SEL_W-1:0]   src_a [ENTRY_NUM];
    logic [SRC_SEL_W-1:0]   src_b [ENTRY_NUM];
    logic [ALU_OP_W-1:0]    alu_op [ENTRY_NUM];
    logic [SPECTAG_LEN-1:0] spectag [ENTRY_NUM];

    logic [ENTRY_NUM-1:0] kill, cand, free;
    logic                 sel_found, dp_kill, dp_accept;
    logic [IDX_W-1:0]     sel_idx, wr_idx;
    logic [CNT_W-1:0]     kill_cnt;

    // Operand capture from the writeback buses; wb0 wins when both match.
    function automatic logic [DATA_LEN:0] capture(input logic rdy, input logic [DATA_LEN-1:0] val);
        if (!rdy && wb0_valid && wb0_tag == val[RRF_SEL-1:0]) return {1'b1, wb0_data};
        if (!rdy && wb1_valid && wb1_tag == val[RRF_SEL-1:0]) return {1'b1, wb1_data};
        return {rdy, val};
    endfunction

    assign dp_ready  = count < CNT_W'(ENTRY_NUM);
    assign dp_kill   = prmiss && dp_specbit && |(dp_spectag & spectagfix);
    assign dp_accept = dp_valid && dp_ready && !dp_kill;

    always_comb begin
        kill      = '0;
        cand      = '0;
        free      = '0;
        kill_cnt  = '0;
        sel_found = 1'b0;
        sel_idx   = '0;
        wr_idx    = '0;
        for (int i = 0; i < ENTRY_NUM; i++) begin
            kill[i]  = valid[i] && prmiss && specbit[i] && |(spectag[i] & spectagfix);
            cand[i]  = valid[i] && rdy1[i] && rdy2[i] && !kill[i];
            kill_cnt = kill_cnt + CNT_W'(kill[i]);
        end
        for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
            if (cand[i]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
        // An entry leaving this cycle (issued or killed) can take the incoming dispatch.
        for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
            free[i] = !valid[i] || kill[i] || (sel_found && sel_idx == IDX_W'(i));
            if (free[i]) wr_idx = IDX_W'(i);
        end
    end

    always_comb begin
        iss_valid   = sel_found;
        iss_src1    = '0;
        iss_src2    = '0;
        iss_pc      = '0;
        iss_imm     = '0;
        iss_rrftag  = '0;
        iss_dstval  = 1'b0;
        iss_src_a   = '0;
        iss_src_b   = '0;
        iss_alu_op  = '0;
        iss_spectag = '0;
        iss_specbit = 1'b0;
        if (sel_found) begin
            iss_src1    = src1[sel_idx];
            iss_src2    = src2[sel_idx];
            iss_pc      = pc[sel_idx];
            iss_imm     = imm[sel_idx];
            iss_rrftag  = rrftag[sel_idx];
            iss_dstval  = dstval[sel_idx];
            iss_src_a   = src_a[sel_idx];
            iss_src_b   = src_b[sel_idx];
            iss_alu_op  = alu_op[sel_idx];
            iss_spectag = spectag[sel_idx];
            iss_specbit = specbit[sel_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= '0;
            count <= '0;
        end else begin
            count <= count + CNT_W'(dp_accept) - CNT_W'(sel_found) - kill_cnt;
            for (int i = 0; i < ENTRY_NUM; i++) begin
                if (kill[i] || (sel_found && sel_idx == IDX_W'(i))) valid[i] <= 1'b0;
                {rdy1[i], src1[i]} <= capture(rdy1[i], src1[i]);
                {rdy2[i], src2[i]} <= capture(rdy2[i], src2[i]);
                if (prsuccess && spectag[i] == spectagfix) specbit[i] <= 1'b0;
            end
            if (dp_accept) begin
                valid[wr_idx]              <= 1'b1;
                {rdy1[wr_idx], src1[wr_idx]} <= capture(dp_rdy1, dp_src1);
                {rdy2[wr_idx], src2[wr_idx]} <= capture(dp_rdy2, dp_src2);
                pc[wr_idx]                 <= dp_pc;
                imm[wr_idx]                <= dp_imm;
                rrftag[wr_idx]             <= dp_rrftag;
                dstval[wr_idx]             <= dp_dstval;
                src_a[wr_idx]              <= dp_src_a;
                src_b[wr_idx]              <= dp_src_b;
                alu_op[wr_idx]             <= dp_alu_op;
                spectag[wr_idx]            <= dp_spectag;
                specbit[wr_idx]            <= dp_specbit && !(prsuccess && dp_spectag == spectagfix);
            end
        end
    end
endmodule

// File: tb/tb_rs_alu_issue_queue.sv
// Bench for rs_alu_issue_queue: directed scenarios plus random traffic against a slot-array model.
module tb_rs_alu_issue_queue;
    logic        clk = 1'b0, reset = 1'b1;
    logic        dp_valid, dp_ready, dp_rdy1, dp_rdy2, dp_dstval, dp_specbit;
    logic [31:0] dp_src1, dp_src2, dp_pc, dp_imm;
    logic [5:0]  dp_rrftag;
    logic [1:0]  dp_src_a, dp_src_b;
    logic [3:0]  dp_alu_op;
    logic [4:0]  dp_spectag, spectagfix;
    logic        wb0_valid, wb1_valid, prmiss, prsuccess;
    logic [5:0]  wb0_tag, wb1_tag;
    logic [31:0] wb0_data, wb1_data;
    logic        iss_valid, iss_dstval, iss_specbit;
    logic [31:0] iss_src1, iss_src2, iss_pc, iss_imm;
    logic [5:0]  iss_rrftag;
    logic [1:0]  iss_src_a, iss_src_b;
    logic [3:0]  iss_alu_op;
    logic [4:0]  iss_spectag;
    logic [3:0]  count;

    int passed = 0, total = 0;

    rs_alu_issue_queue dut (
        .clk(clk), .reset(reset), .dp_valid(dp_valid), .dp_ready(dp_ready),
        .dp_src1(dp_src1), .dp_src2(dp_src2), .dp_rdy1(dp_rdy1), .dp_rdy2(dp_rdy2),
        .dp_pc(dp_pc), .dp_imm(dp_imm), .dp_rrftag(dp_rrftag), .dp_dstval(dp_dstval),
        .dp_src_a(dp_src_a), .dp_src_b(dp_src_b), .dp_alu_op(dp_alu_op),
        .dp_spectag(dp_spectag), .dp_specbit(dp_specbit),
        .wb0_valid(wb0_valid), .wb0_tag(wb0_tag), .wb0_data(wb0_data),
        .wb1_valid(wb1_valid), .wb1_tag(wb1_tag), .wb1_data(wb1_data),
        .prmiss(prmiss), .prsuccess(prsuccess), .spectagfix(spectagfix),
        .iss_valid(iss_valid), .iss_src1(iss_src1), .iss_src2(iss_src2), .iss_pc(iss_pc),
        .iss_imm(iss_imm), .iss_rrftag(iss_rrftag), .iss_dstval(iss_dstval),
        .iss_src_a(iss_src_a), .iss_src_b(iss_src_b), .iss_alu_op(iss_alu_op),
        .iss_spectag(iss_spectag), .iss_specbit(iss_specbit), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        bit v, r1, r2, dst, spec;
        logic [31:0] s1, s2, pc, imm;
        logic [5:0]  tag;
        logic [1:0]  sa, sb;
        logic [3:0]  op;
        logic [4:0]  stag;
    } ent_t;
    ent_t m [8];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic bit m_killed(int i);
        return m[i].v && prmiss && m[i].spec && ((m[i].stag & spectagfix) != 0);
    endfunction

    function automatic int m_pick();
        for (int i = 0; i < 8; i++)
            if (m[i].v && m[i].r1 && m[i].r2 && !m_killed(i)) return i;
        return -1;
    endfunction

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < 8; i++) n += int'(m[i].v);
        return n;
    endfunction

    task automatic model_check();
        int p = m_pick();
        chk("iss_valid", iss_valid, p >= 0);
        if (p >= 0) begin
            chk("iss_srcs", {iss_src1, iss_src2}, {m[p].s1, m[p].s2});
            chk("iss_pc_imm", {iss_pc, iss_imm}, {m[p].pc, m[p].imm});
            chk("iss_ctl", {iss_rrftag, iss_dstval, iss_src_a, iss_src_b, iss_alu_op, iss_spectag, iss_specbit},
                {m[p].tag, m[p].dst, m[p].sa, m[p].sb, m[p].op, m[p].stag, m[p].spec});
        end else begin
            chk("iss_idle_zero", {iss_src1, iss_src2} | {iss_pc, iss_imm}, 64'd0);
        end
        chk("dp_ready", dp_ready, m_count() < 8);
        chk("count", count, m_count());
    endtask

    task automatic model_update();
        int  p = m_pick();
        int  c0 = m_count();
        bit  acc = dp_valid && c0 < 8 && !(prmiss && dp_specbit && ((dp_spectag & spectagfix) != 0));
        for (int i = 0; i < 8; i++) if (m_killed(i)) m[i].v = 0;
        if (p >= 0) m[p].v = 0;
        if (acc) begin
            for (int i = 0; i < 8; i++) begin
                if (!m[i].v) begin
                    m[i] = '{v:1, r1:dp_rdy1, r2:dp_rdy2, dst:dp_dstval, spec:dp_specbit,
                             s1:dp_src1, s2:dp_src2, pc:dp_pc, imm:dp_imm, tag:dp_rrftag,
                             sa:dp_src_a, sb:dp_src_b, op:dp_alu_op, stag:dp_spectag};
                    break;
                end
            end
        end
        // Dispatch bypass and wakeup are the same rule applied to every resident entry.
        for (int i = 0; i < 8; i++) begin
            if (!m[i].v) continue;
            if (!m[i].r1 && wb0_valid && wb0_tag == m[i].s1[5:0]) begin m[i].s1 = wb0_data; m[i].r1 = 1; end
            else if (!m[i].r1 && wb1_valid && wb1_tag == m[i].s1[5:0]) begin m[i].s1 = wb1_data; m[i].r1 = 1; end
            if (!m[i].r2 && wb0_valid && wb0_tag == m[i].s2[5:0]) begin m[i].s2 = wb0_data; m[i].r2 = 1; end
            else if (!m[i].r2 && wb1_valid && wb1_tag == m[i].s2[5:0]) begin m[i].s2 = wb1_data; m[i].r2 = 1; end
            if (prsuccess && m[i].stag == spectagfix) m[i].spec = 0;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        model_check();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        dp_valid = 0; dp_rdy1 = 1; dp_rdy2 = 1; dp_src1 = 0; dp_src2 = 0; dp_pc = 0; dp_imm = 0;
        dp_rrftag = 0; dp_dstval = 0; dp_src_a = 0; dp_src_b = 0; dp_alu_op = 0;
        dp_spectag = 0; dp_specbit = 0; wb0_valid = 0; wb0_tag = 0; wb0_data = 0;
        wb1_valid = 0; wb1_tag = 0; wb1_data = 0; prmiss = 0; prsuccess = 0; spectagfix = 0;
    endtask

    task automatic disp(input logic [31:0] s1, input logic r1, input logic [31:0] s2, input logic r2,
                        input logic [31:0] pcv, input logic sb, input logic [4:0] st);
        idle();
        dp_valid = 1; dp_src1 = s1; dp_rdy1 = r1; dp_src2 = s2; dp_rdy2 = r2; dp_pc = pcv;
        dp_imm = pcv ^ 32'h5A5A; dp_rrftag = pcv[5:0]; dp_dstval = 1; dp_alu_op = pcv[3:0];
        dp_specbit = sb; dp_spectag = st;
    endtask

    task automatic drain(input logic [5:0] tag);
        idle();
        wb0_valid = 1; wb0_tag = tag; wb0_data = 32'hD0D0;
        tick();
        idle();
        for (int k = 0; k < 20 && count != 0; k++) tick();
        chk("drain_empty", count, 4'd0);
    endtask

    initial begin
        idle();
        for (int i = 0; i < 8; i++) m[i] = '0;
        repeat (2) @(posedge clk);
        #1 reset = 0;
        #1;
        chk("reset_count", count, 4'd0);
        chk("reset_dp_ready", dp_ready, 1'b1);
        chk("reset_iss", {iss_valid, iss_src1, iss_pc}, 65'd0);

        // 1: ready op issues the cycle after dispatch
        disp(5, 1, 7, 1, 32'h100, 0, 0);
        chk("t1_no_same_cycle_issue", iss_valid, 1'b0);
        tick();
        idle(); #1;
        chk("t1_iss_valid", iss_valid, 1'b1);
        chk("t1_src", {iss_src1, iss_src2}, {32'd5, 32'd7});
        chk("t1_count1", count, 4'd1);
        tick();
        chk("t1_count0", count, 4'd0);

        // 2: wake on wb1 two cycles after dispatch
        disp(3, 0, 9, 1, 32'h200, 0, 0);
        tick(); idle(); tick();
        wb1_valid = 1; wb1_tag = 3; wb1_data = 32'hAA; #1;
        chk("t2_not_yet", iss_valid, 1'b0);
        tick(); idle(); #1;
        chk("t2_iss_valid", iss_valid, 1'b1);
        chk("t2_src1", iss_src1, 32'hAA);
        tick();

        // 3: bypass on wb0 in the dispatch cycle
        disp(9, 0, 1, 1, 32'h300, 0, 0);
        wb0_valid = 1; wb0_tag = 9; wb0_data = 32'h55;
        wb1_valid = 1; wb1_tag = 9; wb1_data = 32'h66;
        tick(); idle(); #1;
        chk("t3_iss_valid", iss_valid, 1'b1);
        chk("t3_src1_wb0_prio", iss_src1, 32'h55);
        tick();

        // 4: fill all eight entries, ninth dispatch ignored
        for (int i = 0; i < 8; i++) begin disp(20, 0, 1, 1, 32'h400 + i, 0, 0); tick(); end
        idle(); #1;
        chk("t4_full_ready", dp_ready, 1'b0);
        chk("t4_full_count", count, 4'd8);
        disp(1, 1, 1, 1, 32'h4FF, 0, 0);
        tick(); idle(); #1;
        chk("t4_ninth_ignored", count, 4'd8);
        drain(20);

        // 5: mispredict kills two of three speculative entries
        disp(21, 0, 1, 1, 32'h500, 1, 5'b00010); tick();
        disp(21, 0, 1, 1, 32'h501, 1, 5'b00100); tick();
        disp(21, 0, 1, 1, 32'h502, 1, 5'b00010); tick();
        idle(); prmiss = 1; spectagfix = 5'b00010;
        tick(); idle(); #1;
        chk("t5_count_after_kill", count, 4'd1);
        drain(21);

        // 6: issue of entry 0 together with a new dispatch
        disp(32'h11, 1, 1, 1, 32'h600, 0, 0);
        tick();
        disp(32'h22, 1, 2, 1, 32'h601, 0, 0); #1;
        chk("t6_issue_old", iss_src1, 32'h11);
        tick(); idle(); #1;
        chk("t6_count_same", count, 4'd1);
        chk("t6_new_in_entry0", {iss_src1, iss_pc}, {32'h22, 32'h601});
        tick();

        // random traffic
        for (int n = 0; n < 400; n++) begin
            logic [5:0] t1, t2;
            idle();
            t1 = 6'($urandom_range(0, 7));
            t2 = 6'($urandom_range(0, 7));
            dp_valid   = ($urandom_range(0, 9) < 6);
            dp_rdy1    = $urandom_range(0, 1) == 1;
            dp_rdy2    = $urandom_range(0, 1) == 1;
            dp_src1    = dp_rdy1 ? $urandom : (($urandom & 32'hFFFF_FFC0) | 32'(t1));
            dp_src2    = dp_rdy2 ? $urandom : (($urandom & 32'hFFFF_FFC0) | 32'(t2));
            dp_pc      = $urandom;  dp_imm = $urandom;
            dp_rrftag  = 6'($urandom); dp_dstval = 1'($urandom);
            dp_src_a   = 2'($urandom); dp_src_b = 2'($urandom); dp_alu_op = 4'($urandom);
            dp_spectag = 5'(1 << $urandom_range(0, 4));
            dp_specbit = $urandom_range(0, 1) == 1;
            wb0_valid  = $urandom_range(0, 1) == 1; wb0_tag = 6'($urandom_range(0, 7)); wb0_data = $urandom;
            wb1_valid  = $urandom_range(0, 1) == 1; wb1_tag = 6'($urandom_range(0, 7)); wb1_data = $urandom;
            spectagfix = 5'(1 << $urandom_range(0, 4));
            case ($urandom_range(0, 15))
                0: prmiss = 1;
                1, 2: prsuccess = 1;
                default: ;
            endcase
            tick();
        end
        idle();
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
